// File: rtl/divider_pkg.sv
// Shared types and helpers for the programmable down-counting divider.
package divider_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // A divisor of zero behaves as divide-by-one so the counter never underflows.
    function automatic logic [31:0] eff_div(input logic [31:0] n);
        return (n == 32'd0) ? 32'd1 : n;
    endfunction

endpackage

// File: rtl/divider_load_shadow.sv
// Shadow register for divisor updates requested while the divider is running;
// the held value is released at the next reload and load_ready reopens after it.
module divider_load_shadow #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] div_value,
    input  logic             in_run,
    input  logic             reload,
    output logic             load_ready,
    output logic             pending,
    output logic [WIDTH-1:0] shadow_value
);

    logic             pending_q, pending_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic             capture;

    // A transfer on a reload edge goes straight to the divisor, so only mid-count loads are held.
    always_comb begin
        capture   = load_valid && !pending_q && in_run && !reload;
        pending_d = pending_q;
        if (reload) begin
            pending_d = 1'b0;
        end else if (capture) begin
            pending_d = 1'b1;
        end
        shadow_d = capture ? div_value : shadow_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_q <= 1'b0;
            shadow_q  <= '0;
        end else begin
            pending_q <= pending_d;
            shadow_q  <= shadow_d;
        end
    end

    assign load_ready   = !pending_q;
    assign pending      = pending_q;
    assign shadow_value = shadow_q;

endmodule

// File: rtl/clock_divider_down.sv
// Programmable down-counting divider: terminal tick plus optional divided waveform.
// Define DIV_CLK_OUT_EN to build the registered div_clk output; otherwise div_clk is tied low.
module clock_divider_down
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] div_value,
    input  logic             load_valid,
    output logic             load_ready,
    output logic [WIDTH-1:0] count_out,
    output logic             tick,
    output logic             div_clk
);

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(DEFAULT_DIV);
    localparam logic [WIDTH-1:0] RST_CNT = WIDTH'(DEFAULT_DIV - 1);

    function automatic logic [WIDTH-1:0] eff_w(input logic [WIDTH-1:0] n);
        return WIDTH'(eff_div(32'(n)));
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             transfer;
    logic             reload_run;
    logic             shadow_pending;
    logic [WIDTH-1:0] shadow_value;

    divider_load_shadow #(.WIDTH(WIDTH)) u_shadow (
        .clock        (clock),
        .reset        (reset),
        .load_valid   (load_valid),
        .div_value    (div_value),
        .in_run       (state_q == RUN),
        .reload       (reload_run),
        .load_ready   (load_ready),
        .pending      (shadow_pending),
        .shadow_value (shadow_value)
    );

    // Leaving RUN counts as a reload so a held divisor is never stranded in the shadow.
    always_comb begin
        transfer   = load_valid && load_ready;
        reload_run = (state_q == RUN) && ((cnt_q == '0) || !enable);

        div_d = div_q;
        if (transfer && ((state_q == IDLE) || reload_run)) begin
            div_d = div_value;
        end else if (reload_run && shadow_pending) begin
            div_d = shadow_value;
        end

        state_d = enable ? RUN : IDLE;

        if ((state_q == RUN) && !reload_run) begin
            cnt_d = cnt_q - ONE;
        end else begin
            cnt_d = eff_w(div_d) - ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            div_q   <= RST_DIV;
            cnt_q   <= RST_CNT;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    assign count_out = cnt_q;
    assign tick      = (state_q == RUN) && (cnt_q == '0);

`ifdef DIV_CLK_OUT_EN
    logic div_clk_q, div_clk_d;

    // Decoded from next-state values so the registered output lines up with count_out.
    always_comb begin
        div_clk_d = (state_d == RUN) && (cnt_d >= (eff_w(div_d) >> 1));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_clk_q <= 1'b0;
        end else begin
            div_clk_q <= div_clk_d;
        end
    end

    assign div_clk = div_clk_q;
`else
    assign div_clk = 1'b0;
`endif

endmodule
